// File: rtl/neuron_pkg.sv
// ---------------------------------------------------------------------------
// neuron_pkg
// Shared definitions for the neuron MAC sequencer:
//   - state_t       : controller state encoding
//   - SM_W / PROD_W : sign-magnitude operand and product widths
//   - sm8_to_twos   : 8-bit sign-magnitude  -> 9-bit two's complement
//   - sm16_to_twos  : 16-bit sign-magnitude -> 17-bit two's complement
// Negative zero maps to 0 in both conversions because -0 == 0.
// ---------------------------------------------------------------------------
package neuron_pkg;

    localparam int SM_W   = 8;
    localparam int PROD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_BIAS,
        ST_ACT,
        ST_DONE
    } state_t;

    function automatic logic signed [SM_W:0] sm8_to_twos(input logic [SM_W-1:0] v);
        logic signed [SM_W:0] mag;
        mag = {2'b00, v[SM_W-2:0]};
        return v[SM_W-1] ? -mag : mag;
    endfunction

    function automatic logic signed [PROD_W:0] sm16_to_twos(input logic [PROD_W-1:0] v);
        logic signed [PROD_W:0] mag;
        mag = {2'b00, v[PROD_W-2:0]};
        return v[PROD_W-1] ? -mag : mag;
    endfunction

endpackage

// File: rtl/sm_to_twos.sv
// ---------------------------------------------------------------------------
// sm_to_twos
// Sign-magnitude to OUT_W-bit two's complement converter. IN_W selects the
// 8-bit (bias) or 16-bit (product) flavour. Negative zero yields 0.
//   sm   in  IN_W   sign-magnitude value (MSB = sign)
//   twos out OUT_W  sign-extended two's complement value
// ---------------------------------------------------------------------------
module sm_to_twos
    import neuron_pkg::*;
#(
    parameter int IN_W  = SM_W,
    parameter int OUT_W = 20
) (
    input  logic [IN_W-1:0]         sm,
    output logic signed [OUT_W-1:0] twos
);

    generate
        if (IN_W == SM_W) begin : g_sm8
            logic signed [SM_W:0] narrow;
            assign narrow = sm8_to_twos(sm);
            assign twos   = OUT_W'(narrow);
        end else begin : g_sm16
            logic signed [PROD_W:0] narrow;
            assign narrow = sm16_to_twos(sm);
            assign twos   = OUT_W'(narrow);
        end
    endgenerate

endmodule

// File: rtl/neuron_mac_sequencer.sv
// ---------------------------------------------------------------------------
// neuron_mac_sequencer
// Time-shares one external 8-bit sign-magnitude multiplier across the
// NUM_INPUTS input/weight pairs of a neuron, accumulates the products in
// two's complement, adds a bias and applies ReLU + shift + saturation.
//   clk, rst            clock, synchronous active-high reset
//   start               begin an evaluation (only honoured in IDLE)
//   bias                sign-magnitude bias, latched with start
//   in_valid/in_ready   input pair handshake, x_in / w_in operands
//   mul_a, mul_b        registered operands to the shared multiplier
//   mul_p               multiplier product, MUL_LAT cycles after operands
//   busy                high whenever not IDLE
//   out_valid/out_ready result handshake, y = activation (bit7 = 0)
// ---------------------------------------------------------------------------
module neuron_mac_sequencer
    import neuron_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int MUL_LAT    = 1,
    parameter int ACC_W      = 20,
    parameter int SHIFT      = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SM_W-1:0]   bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SM_W-1:0]   x_in,
    input  logic [SM_W-1:0]   w_in,
    output logic [SM_W-1:0]   mul_a,
    output logic [SM_W-1:0]   mul_b,
    input  logic [PROD_W-1:0] mul_p,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SM_W-1:0]   y
);

    localparam int CNT_W = $clog2(NUM_INPUTS) + 1;
    localparam int WC_W  = $clog2(MUL_LAT) + 1;

    state_t                   state_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic [CNT_W-1:0]         cnt_reg;
    logic [WC_W-1:0]          wcnt_reg;
    logic [SM_W-1:0]          bias_reg;
    logic [SM_W-1:0]          mul_a_reg;
    logic [SM_W-1:0]          mul_b_reg;
    logic [SM_W-1:0]          y_reg;
    logic                     in_ready_reg;
    logic                     busy_reg;
    logic                     out_valid_reg;

    logic signed [ACC_W-1:0]  prod_twos;
    logic signed [ACC_W-1:0]  bias_twos;
    logic [ACC_W-1:0]         shifted;
    logic [SM_W-1:0]          y_next;

    sm_to_twos #(.IN_W(PROD_W), .OUT_W(ACC_W)) u_prod_conv (
        .sm   (mul_p),
        .twos (prod_twos)
    );

    sm_to_twos #(.IN_W(SM_W), .OUT_W(ACC_W)) u_bias_conv (
        .sm   (bias_reg),
        .twos (bias_twos)
    );

    // ReLU: non-positive sums give 0; positive sums are shifted as unsigned
    // values and saturated to the 7-bit magnitude range.
    always_comb begin
        shifted = $unsigned(acc_reg) >> SHIFT;
        y_next  = '0;
        if (!acc_reg[ACC_W-1] && (acc_reg != '0)) begin
            y_next = (shifted > ACC_W'(127)) ? 8'h7F : {1'b0, shifted[6:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            wcnt_reg      <= '0;
            bias_reg      <= '0;
            mul_a_reg     <= '0;
            mul_b_reg     <= '0;
            y_reg         <= '0;
            in_ready_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        acc_reg      <= '0;
                        cnt_reg      <= '0;
                        bias_reg     <= bias;
                        in_ready_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                        state_reg    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (in_valid) begin
                        mul_a_reg    <= x_in;
                        mul_b_reg    <= w_in;
                        wcnt_reg     <= WC_W'(MUL_LAT - 1);
                        in_ready_reg <= 1'b0;
                        state_reg    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // wcnt reaching 0 marks the cycle in which mul_p is valid
                    if (wcnt_reg == '0) begin
                        acc_reg <= acc_reg + prod_twos;
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (cnt_reg == CNT_W'(NUM_INPUTS - 1)) begin
                            state_reg <= ST_BIAS;
                        end else begin
                            in_ready_reg <= 1'b1;
                            state_reg    <= ST_ISSUE;
                        end
                    end else begin
                        wcnt_reg <= wcnt_reg - WC_W'(1);
                    end
                end
                ST_BIAS: begin
                    acc_reg   <= acc_reg + bias_twos;
                    state_reg <= ST_ACT;
                end
                ST_ACT: begin
                    y_reg         <= y_next;
                    out_valid_reg <= 1'b1;
                    state_reg     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign busy      = busy_reg;
    assign out_valid = out_valid_reg;
    assign y         = y_reg;
    assign mul_a     = mul_a_reg;
    assign mul_b     = mul_b_reg;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_neuron_mac_sequencer
// Two sequencers (SHIFT=7 and SHIFT=0) share all inputs and run in lockstep,
// each with its own combinational sign-magnitude multiplier model. Results
// are compared against an integer reference of the neuron arithmetic.
// ---------------------------------------------------------------------------
module tb_neuron_mac_sequencer;

    localparam int NI      = 4;
    localparam int ML      = 1;
    localparam int EXP_LAT = NI * (1 + ML) + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst, start, in_valid, out_ready;
    logic [7:0]  bias, x_in, w_in;

    logic        in_ready, busy, out_valid;
    logic [7:0]  mul_a, mul_b, y;
    logic [15:0] mul_p;

    logic        in_ready_z, busy_z, out_valid_z;
    logic [7:0]  mul_a_z, mul_b_z, y_z;
    logic [15:0] mul_p_z;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] cur_x [NI];
    logic [7:0] cur_w [NI];
    logic [7:0] cur_b;
    logic [7:0] prev_a = 8'h00;
    logic [7:0] prev_b = 8'h00;

    function automatic logic [15:0] mul_model(input logic [7:0] a, input logic [7:0] b);
        logic [13:0] m;
        m = 14'(a[6:0]) * 14'(b[6:0]);
        return {a[7] ^ b[7], 1'b0, m};
    endfunction

    assign mul_p   = mul_model(mul_a, mul_b);
    assign mul_p_z = mul_model(mul_a_z, mul_b_z);

    neuron_mac_sequencer #(.NUM_INPUTS(NI), .MUL_LAT(ML), .ACC_W(20), .SHIFT(7)) dut (
        .clk(clk), .rst(rst), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .w_in(w_in),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .y(y)
    );

    neuron_mac_sequencer #(.NUM_INPUTS(NI), .MUL_LAT(ML), .ACC_W(20), .SHIFT(0)) dut_z (
        .clk(clk), .rst(rst), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready_z), .x_in(x_in), .w_in(w_in),
        .mul_a(mul_a_z), .mul_b(mul_b_z), .mul_p(mul_p_z), .busy(busy_z),
        .out_valid(out_valid_z), .out_ready(out_ready), .y(y_z)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Signed value of an 8-bit sign-magnitude number.
    function automatic int sm_val(input logic [7:0] v);
        return v[7] ? -int'(v[6:0]) : int'(v[6:0]);
    endfunction

    function automatic int ref_sum();
        int s;
        s = sm_val(cur_b);
        for (int i = 0; i < NI; i++) s += sm_val(cur_x[i]) * sm_val(cur_w[i]);
        return s;
    endfunction

    function automatic logic [7:0] ref_y(input int shift);
        int s;
        int m;
        s = ref_sum();
        if (s <= 0) return 8'h00;
        m = s >>> shift;
        return (m > 127) ? 8'h7F : 8'(m);
    endfunction

    task automatic load(input logic [31:0] xp, input logic [31:0] wp, input logic [7:0] b);
        for (int i = 0; i < NI; i++) begin
            cur_x[i] = xp[8*i +: 8];
            cur_w[i] = wp[8*i +: 8];
        end
        cur_b = b;
    endtask

    // Presents one pair after 'gap' idle cycles; operands must not move until accepted.
    task automatic feed_pair(input logic [7:0] xv, input logic [7:0] wv, input int gap, input bit poke);
        int guard;
        repeat (gap) begin
            in_valid = 1'b0;
            x_in     = 8'($urandom);
            w_in     = 8'($urandom);
            start    = poke;
            @(negedge clk);
            check("gap_mul_a", mul_a, prev_a);
            check("gap_mul_b", mul_b, prev_b);
        end
        start    = 1'b0;
        in_valid = 1'b1;
        x_in     = xv;
        w_in     = wv;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
            check("wait_mul_a", mul_a, prev_a);
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        prev_a   = xv;
        prev_b   = wv;
        check("mul_a", mul_a, xv);
        check("mul_b", mul_b, wv);
    endtask

    task automatic run_eval(input string name, input bit gaps, input int hold);
        int t0;
        int guard;
        logic [7:0] e7;
        logic [7:0] e0;
        logic [7:0] y_seen;
        out_ready = (hold == 0);
        @(negedge clk);
        start = 1'b1;
        bias  = cur_b;
        @(negedge clk);
        start = 1'b0;
        bias  = 8'($urandom);
        t0    = cyc;
        for (int k = 0; k < NI; k++)
            feed_pair(cur_x[k], cur_w[k], gaps ? int'($urandom_range(0, 3)) : 0, gaps);
        start = 1'b0;
        guard = 0;
        while (!out_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_out_valid"}, out_valid, 1);
        if (!gaps) check({name, "_latency"}, cyc - t0, EXP_LAT);
        e7 = ref_y(7);
        e0 = ref_y(0);
        y_seen = y;
        check({name, "_y"}, y, e7);
        check({name, "_y_shift0"}, y_z, e0);
        check({name, "_busy"}, busy, 1);
        $display("eval %-10s sum=%0d y=%02h exp=%02h y_shift0=%02h exp=%02h",
                 name, ref_sum(), y, e7, y_z, e0);
        repeat (hold) begin
            start = 1'b1;
            @(negedge clk);
            check({name, "_hold_valid"}, out_valid, 1);
            check({name, "_hold_y"}, y, y_seen);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_valid_drop"}, out_valid, 0);
        check({name, "_busy_drop"}, busy, 0);
        repeat (2) @(negedge clk);
        check({name, "_idle_after"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        bias = 8'h00; x_in = 8'h00; w_in = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 8'h00);
        check("rst_mul_a", mul_a, 8'h00);
        check("rst_mul_b", mul_b, 8'h00);

        load({8'd40, 8'd30, 8'd20, 8'd10}, {4{8'h40}}, 8'h00);
        run_eval("positive", 1'b0, 0);
        check("positive_const", y, 8'h32);

        load({8'd40, 8'd30, 8'd20, 8'd10}, {4{8'hC0}}, 8'h05);
        run_eval("relu", 1'b0, 0);

        load({4{8'h7F}}, {4{8'h7F}}, 8'h7F);
        run_eval("saturate", 1'b0, 0);

        load({4{8'h00}}, {4{8'h85}}, 8'h05);
        run_eval("negzero", 1'b0, 0);
        check("negzero_const", y_z, 8'h05);

        load({8'd40, 8'd30, 8'd20, 8'd10}, {4{8'h40}}, 8'h00);
        run_eval("backpress", 1'b1, 3);

        // Reset after two accepted pairs.
        @(negedge clk);
        start = 1'b1;
        bias  = 8'h00;
        @(negedge clk);
        start = 1'b0;
        feed_pair(8'd10, 8'h40, 0, 1'b0);
        feed_pair(8'd20, 8'h40, 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        prev_a = 8'h00;
        prev_b = 8'h00;
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_y", y, 8'h00);
        check("mid_rst_mul_a", mul_a, 8'h00);
        check("mid_rst_mul_b", mul_b, 8'h00);
        $display("eval %-10s reset after 2 pairs", "reset");
        load({8'd40, 8'd30, 8'd20, 8'd10}, {4{8'h40}}, 8'h00);
        run_eval("post_rst", 1'b0, 0);

        for (int r = 0; r < 10; r++) begin
            load($urandom, $urandom, 8'($urandom));
            run_eval($sformatf("rand%0d", r), r[0], int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/neuron_mac_sequencer.md
# neuron_mac_sequencer

Controller that time-shares one 8-bit sign-magnitude multiplier across the inputs of a single neuron. It accepts NUM_INPUTS input/weight pairs over a valid/ready stream and issues each pair to the external multiplier. It accumulates the products in two's complement, adds a bias, and applies ReLU with shift and saturation. The result is presented as one 8-bit sign-magnitude output. It sits between the neuron's input buffer and the activation output, and owns the multiplier's operand ports.

## Interface
- NUM_INPUTS, 4: pairs per neuron evaluation (>=1)
- MUL_LAT, 1: cycles from operand register update to valid product on mul_p (>=1)
- ACC_W, 20: accumulator width; must be >= 17 + clog2(NUM_INPUTS)
- SHIFT, 7: right shift applied to the positive sum before saturation
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin evaluation; sampled only in IDLE
- bias  in  8  sign-magnitude bias, sampled at the start handshake
- in_valid / in_ready  in/out  1  input pair handshake
- x_in, w_in  in  8  sign-magnitude input and weight (bit7 sign, 6:0 magnitude)
- mul_a, mul_b  out  8  registered operands to the shared multiplier
- mul_p  in  16  multiplier product ({sign, 15-bit magnitude})
- busy  out  1  high in every state except IDLE
- out_valid / out_ready  out/in  1  result handshake
- y  out  8  sign-magnitude activation result (bit7 always 0)

## Operation
- States:
  - IDLE: start=1 → ISSUE. Clear acc and cnt, latch bias.
  - ISSUE: in_ready=1. On in_valid&in_ready, register x_in→mul_a and w_in→mul_b, load wcnt=MUL_LAT-1, go to WAIT.
  - WAIT: decrement wcnt. When wcnt==0, convert mul_p, add it to acc, and increment cnt. If cnt was NUM_INPUTS-1 go to BIAS, else go to ISSUE.
  - BIAS: acc += bias converted to two's complement → ACT.
  - ACT: register y → DONE.
  - DONE: out_valid=1. On out_ready go to IDLE.
- Product conversion: magnitude mul_p[14:0] zero-extended. Negate when mul_p[15]=1 and magnitude≠0. Negative zero (16'h8000) contributes 0.
- Activation:
  - If acc<=0, y=0.
  - Otherwise m=acc>>SHIFT (logical shift on the positive value) and y={1'b0, min(m,127)}.
- start in any non-IDLE state is ignored. in_valid outside ISSUE is ignored, and in_ready is 0 there.
- mul_a/mul_b hold their value until the next accept. Reset value is 0.

## Timing
- Reset values: state=IDLE; in_ready, busy, out_valid = 0; y, mul_a, mul_b = 8'h00; acc=0; cnt=0.
- With start sampled at edge 0 and in_valid held high:
  - pair k is accepted at edge 1+k(1+MUL_LAT);
  - its product is accumulated MUL_LAT edges later;
  - out_valid rises after edge NUM_INPUTS(1+MUL_LAT)+2.
  - Defaults give edge 10.
- mul_p is sampled exactly MUL_LAT cycles after the mul_a/mul_b update.
- y and out_valid are stable while out_valid=1 and out_ready=0.
- out_ready high in the same cycle out_valid rises completes the transfer at that edge.
- busy drops the cycle after the output transfer.
- rst at any edge overrides everything. The next cycle is IDLE with all reset values, and any in-flight pair or result is discarded.

## Structure
- Shared package (neuron_pkg): state enum, sign-magnitude width constant (8), product width (16), a sm8-to-two's-complement function and a sm16-to-two's-complement function.
- One natural sub-module: sm_to_twos (sign-magnitude to ACC_W two's complement with negative-zero clamp), used for both product and bias.
- The multiplier itself stays outside this block. The controller only drives its operand ports.

## Test plan
Defaults apply unless stated: NUM_INPUTS=4, MUL_LAT=1, SHIFT=7, combinational multiplier model.
- Positive sum: x={10,20,30,40}, w all 8'h40, bias=0 → sum 6400, y=8'h32, out_valid after edge 10.
- ReLU clamp: x={10,20,30,40}, w all 8'hC0 (−64), bias=8'h05 → acc=−6395, y=8'h00.
- Saturation: all x=w=8'h7F, bias=8'h7F → acc=64643, m=505, y=8'h7F.
- Negative zero, instance SHIFT=0: x all 8'h00, w all 8'h85, bias=8'h05 → products 16'h8000 contribute 0, y=8'h05.
- Backpressure: random in_valid gaps, out_ready low 3 cycles, start pulsed while busy → y and out_valid held; no extra evaluation; mul_a/mul_b change only on accepts; result matches the first test.
- Reset mid-operation: assert rst after 2 pairs accepted → next cycle all outputs 0, busy=0. A fresh start with the first test's stimulus yields y=8'h32.
